// File: rtl/led_pattern_sequencer_pkg.sv
// Shared definitions for the LED pattern sequencer: FSM state encoding,
// mode constants and small helpers for mapping modes onto states.
package led_seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_CHASE     = 3'd1,
    ST_BOUNCE_UP = 3'd2,
    ST_BOUNCE_DN = 3'd3,
    ST_BLINK     = 3'd4
  } seq_state_e;

  localparam logic [1:0] MODE_CHASE  = 2'd0;
  localparam logic [1:0] MODE_BOUNCE = 2'd1;
  localparam logic [1:0] MODE_BLINK  = 2'd2;
  localparam logic [1:0] MODE_OFF    = 2'd3;

  // True when an active state belongs to the requested mode; IDLE never matches,
  // so a step from IDLE always takes the entry path.
  function automatic logic modeMatches(input seq_state_e st, input logic [1:0] mode);
    case (st)
      ST_CHASE:                   return mode == MODE_CHASE;
      ST_BOUNCE_UP, ST_BOUNCE_DN: return mode == MODE_BOUNCE;
      ST_BLINK:                   return mode == MODE_BLINK;
      default:                    return 1'b0;
    endcase
  endfunction

  // State a mode starts in; bounce always starts going up.
  function automatic seq_state_e entryState(input logic [1:0] mode);
    case (mode)
      MODE_BOUNCE: return ST_BOUNCE_UP;
      MODE_BLINK:  return ST_BLINK;
      default:     return ST_CHASE;
    endcase
  endfunction

endpackage

// File: rtl/led_pattern_sequencer_if.sv
// Control/status bundle between the flasher side and the LED pattern sequencer.
interface led_pattern_sequencer_if #(
  parameter int NUM_LEDS = 5,
  parameter int PWM_BITS = 8
) ();

  localparam int POS_BITS = (NUM_LEDS < 2) ? 1 : $clog2(NUM_LEDS);

  logic                i_flash;
  logic                i_enable;
  logic [1:0]          i_mode;
  logic [PWM_BITS-1:0] i_duty;
  logic [NUM_LEDS-1:0] o_led;
  logic                o_step;
  logic [POS_BITS-1:0] o_pos;

  modport master (
    output i_flash, i_enable, i_mode, i_duty,
    input  o_led, o_step, o_pos
  );

  modport slave (
    input  i_flash, i_enable, i_mode, i_duty,
    output o_led, o_step, o_pos
  );

endinterface

// File: rtl/led_pattern_sequencer_flash_edge_detect.sv
// Brings the asynchronous flash bit into the refclk domain and flags every
// transition (rising or falling) as one pattern step.
module flash_edge_detect (
  input  logic refclk,
  input  logic reset,
  input  logic flash_i,
  output logic edge_o,
  output logic step_o
);

  logic syncMeta_q;
  logic syncOut_q;
  logic prevFlash_q;
  logic step_q;

  // Two-flop synchronizer, previous-value register and the registered step pulse.
  always_ff @(posedge refclk or posedge reset) begin
    if (reset) begin
      syncMeta_q  <= 1'b0;
      syncOut_q   <= 1'b0;
      prevFlash_q <= 1'b0;
      step_q      <= 1'b0;
    end else begin
      syncMeta_q  <= flash_i;
      syncOut_q   <= syncMeta_q;
      prevFlash_q <= syncOut_q;
      step_q      <= syncOut_q ^ prevFlash_q;
    end
  end

  // The unregistered detect lets the pattern FSM update on the same edge
  // that raises the registered step pulse.
  assign edge_o = syncOut_q ^ prevFlash_q;
  assign step_o = step_q;

endmodule

// File: rtl/led_pattern_sequencer.sv
// Advances a chase / bounce / blink pattern across the LED bank on every
// flash-bit transition, and dims the lit LEDs with a free-running PWM.
module led_pattern_sequencer
  import led_seq_pkg::*;
#(
  parameter int NUM_LEDS = 5,
  parameter int PWM_BITS = 8
) (
  input logic refclk,
  input logic reset,
  led_pattern_sequencer_if.slave bus
);

  localparam int POS_BITS = (NUM_LEDS < 2) ? 1 : $clog2(NUM_LEDS);
  localparam logic [POS_BITS-1:0] LAST_POS = POS_BITS'(NUM_LEDS - 1);

  if (NUM_LEDS < 2) begin : g_numLedsCheck
    $error("led_pattern_sequencer: NUM_LEDS must be at least 2");
  end

  logic                flashEdge;
  logic                stepPulse;
  seq_state_e          state_q;
  logic [POS_BITS-1:0] pos_q;
  logic                phase_q;
  logic [NUM_LEDS-1:0] pattern_q;
  logic [PWM_BITS-1:0] pwmCount_q;
  logic [PWM_BITS-1:0] dutyReg_q;
  logic [NUM_LEDS-1:0] led_q;
  logic [POS_BITS-1:0] upPos_d;
  logic [POS_BITS-1:0] downPos_d;
  logic [POS_BITS-1:0] chasePos_d;

  function automatic logic [NUM_LEDS-1:0] posMask(input logic [POS_BITS-1:0] p);
    logic [NUM_LEDS-1:0] one;
    one = {{(NUM_LEDS-1){1'b0}}, 1'b1};
    return one << p;
  endfunction

  flash_edge_detect u_flashEdge (
    .refclk  (refclk),
    .reset   (reset),
    .flash_i (bus.i_flash),
    .edge_o  (flashEdge),
    .step_o  (stepPulse)
  );

  assign upPos_d    = pos_q + 1'b1;
  assign downPos_d  = pos_q - 1'b1;
  assign chasePos_d = (pos_q == LAST_POS) ? '0 : upPos_d;

  // Pattern FSM: disable/off wins immediately, otherwise steps either
  // (re)enter the requested mode or advance the current one.
  always_ff @(posedge refclk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      pos_q     <= '0;
      phase_q   <= 1'b0;
      pattern_q <= '0;
    end else if (!bus.i_enable || bus.i_mode == MODE_OFF) begin
      state_q   <= ST_IDLE;
      pos_q     <= '0;
      phase_q   <= 1'b0;
      pattern_q <= '0;
    end else if (flashEdge) begin
      if (!modeMatches(state_q, bus.i_mode)) begin
        state_q   <= entryState(bus.i_mode);
        pos_q     <= '0;
        phase_q   <= (bus.i_mode == MODE_BLINK);
        pattern_q <= (bus.i_mode == MODE_BLINK) ? {NUM_LEDS{1'b1}} : posMask('0);
      end else begin
        case (state_q)
          ST_CHASE: begin
            pos_q     <= chasePos_d;
            pattern_q <= posMask(chasePos_d);
          end
          ST_BOUNCE_UP: begin
            pos_q     <= upPos_d;
            pattern_q <= posMask(upPos_d);
            if (upPos_d == LAST_POS) state_q <= ST_BOUNCE_DN;
          end
          ST_BOUNCE_DN: begin
            pos_q     <= downPos_d;
            pattern_q <= posMask(downPos_d);
            if (downPos_d == '0) state_q <= ST_BOUNCE_UP;
          end
          ST_BLINK: begin
            phase_q   <= ~phase_q;
            pattern_q <= phase_q ? {NUM_LEDS{1'b0}} : {NUM_LEDS{1'b1}};
          end
          default: begin
            state_q   <= ST_IDLE;
            pos_q     <= '0;
            phase_q   <= 1'b0;
            pattern_q <= '0;
          end
        endcase
      end
    end
  end

  // Free-running PWM; duty only reloads at the wrap so a change never glitches.
  always_ff @(posedge refclk or posedge reset) begin
    if (reset) begin
      pwmCount_q <= '0;
      dutyReg_q  <= '0;
      led_q      <= '0;
    end else begin
      pwmCount_q <= pwmCount_q + 1'b1;
      if (pwmCount_q == '0) dutyReg_q <= bus.i_duty;
      led_q <= pattern_q & {NUM_LEDS{pwmCount_q < dutyReg_q}};
    end
  end

  assign bus.o_led  = led_q;
  assign bus.o_step = stepPulse;
  assign bus.o_pos  = pos_q;

endmodule

// File: tb/tb_led_pattern_sequencer.sv
// Self-checking bench for led_pattern_sequencer: directed scenarios plus a
// randomized mode/spacing run, checked against a position/pattern model.
module tb_led_pattern_sequencer;
  import led_seq_pkg::*;

  localparam int NUM_LEDS = 5;
  localparam int PWM_BITS = 8;

  logic refclk = 1'b0;
  logic reset;

  always #5 refclk = ~refclk;

  led_pattern_sequencer_if #(.NUM_LEDS(NUM_LEDS), .PWM_BITS(PWM_BITS)) bus ();

  led_pattern_sequencer #(.NUM_LEDS(NUM_LEDS), .PWM_BITS(PWM_BITS)) dut (
    .refclk (refclk),
    .reset  (reset),
    .bus    (bus)
  );

  int vectors = 0;
  int miscompares = 0;

  // Reference model: whether a pattern is running, which mode, and how many
  // steps have elapsed since the mode was entered.
  bit mActive = 1'b0;
  int mMode = 0;
  int mK = 0;

  function automatic int refPos(input int mode, input int k);
    int m;
    if (mode == 0) return k % NUM_LEDS;
    if (mode == 1) begin
      m = k % (2 * NUM_LEDS - 2);
      return (m < NUM_LEDS) ? m : (2 * NUM_LEDS - 2 - m);
    end
    return 0;
  endfunction

  function automatic logic [NUM_LEDS-1:0] refPattern(input bit active, input int mode, input int k);
    logic [NUM_LEDS-1:0] one;
    one = 1;
    if (!active) return '0;
    if (mode == 2) return (k % 2 == 0) ? {NUM_LEDS{1'b1}} : {NUM_LEDS{1'b0}};
    return one << refPos(mode, k);
  endfunction

  function automatic int expPos();
    return mActive ? refPos(mMode, mK) : 0;
  endfunction

  function automatic logic [NUM_LEDS-1:0] expPat();
    return refPattern(mActive, mMode, mK);
  endfunction

  task automatic modelStep(input bit en, input int mode);
    if (!en || mode == 3) begin
      mActive = 1'b0;
      mK = 0;
    end else if (!mActive || mode != mMode) begin
      mActive = 1'b1;
      mMode = mode;
      mK = 0;
    end else begin
      mK++;
    end
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Toggle the flash bit at a negedge, then check step latency/width and position.
  task automatic applyStimulus(input int mode, input string tag);
    logic s0, s1, s2;
    logic [31:0] posSeen;
    bus.i_mode = 2'(mode);
    bus.i_flash = ~bus.i_flash;
    modelStep(bus.i_enable, mode);
    @(posedge refclk); @(negedge refclk); s0 = bus.o_step;
    @(posedge refclk); @(negedge refclk); s1 = bus.o_step;
    @(posedge refclk); @(negedge refclk); s2 = bus.o_step;
    posSeen = 32'(bus.o_pos);
    checkOutput({tag, "_latency"}, {29'd0, s0, s1, s2}, 32'b001);
    checkOutput({tag, "_pos"}, posSeen, 32'(expPos()));
    @(posedge refclk); @(negedge refclk);
    checkOutput({tag, "_width"}, {31'd0, bus.o_step}, 32'd0);
  endtask

  // With full duty, LEDs must show the expected pattern except for at most one
  // dark PWM slot, and no stray step may appear.
  task automatic checkLedFull(input int len, input string tag);
    int match, zero, stray;
    logic [NUM_LEDS-1:0] pat;
    match = 0; zero = 0; stray = 0;
    pat = expPat();
    for (int i = 0; i < len; i++) begin
      @(posedge refclk); @(negedge refclk);
      if (bus.o_step) stray++;
      if (bus.o_led === pat) match++;
      else if (bus.o_led === '0) zero++;
    end
    checkOutput({tag, "_led"}, {31'd0, (stray == 0 && match + zero == len && zero <= 1)}, 32'd1);
  endtask

  // Count on-cycles per LED over one full PWM period.
  task automatic checkLedDuty(input int duty, input string tag);
    int onCount [NUM_LEDS];
    logic [NUM_LEDS-1:0] pat;
    pat = expPat();
    for (int j = 0; j < NUM_LEDS; j++) onCount[j] = 0;
    for (int i = 0; i < (1 << PWM_BITS); i++) begin
      @(posedge refclk); @(negedge refclk);
      for (int j = 0; j < NUM_LEDS; j++) if (bus.o_led[j] === 1'b1) onCount[j]++;
    end
    for (int j = 0; j < NUM_LEDS; j++)
      checkOutput($sformatf("%s_duty_led%0d", tag, j), 32'(onCount[j]), pat[j] ? 32'(duty) : 32'd0);
  endtask

  initial begin
    int bad;
    int mode;
    reset = 1'b1;
    bus.i_flash = 1'b0;
    bus.i_enable = 1'b1;
    bus.i_mode = MODE_CHASE;
    bus.i_duty = 8'd255;

    // Reset held, then released with the flash bit static.
    repeat (5) @(negedge refclk);
    checkOutput("in_reset", {24'd0, bus.o_led, bus.o_step, bus.o_pos}, 32'd0);
    reset = 1'b0;
    bad = 0;
    for (int i = 0; i < 1000; i++) begin
      @(posedge refclk); @(negedge refclk);
      if (bus.o_led !== '0 || bus.o_step !== 1'b0 || bus.o_pos !== '0) bad++;
    end
    checkOutput("idle_static", 32'(bad), 32'd0);

    // Chase: 12 toggles spaced 50 cycles.
    for (int i = 0; i < 12; i++) begin
      applyStimulus(0, $sformatf("chase%0d", i));
      checkLedFull(46, $sformatf("chase%0d", i));
    end

    // Bounce: 10 toggles.
    for (int i = 0; i < 10; i++) begin
      applyStimulus(1, $sformatf("bounce%0d", i));
      checkLedFull(40, $sformatf("bounce%0d", i));
    end

    // Chase to pos 3, switch to bounce, then drop enable mid-pattern.
    for (int i = 0; i < 4; i++) begin
      applyStimulus(0, $sformatf("pre_switch%0d", i));
      checkLedFull(30, $sformatf("pre_switch%0d", i));
    end
    applyStimulus(1, "switch_bounce");
    checkLedFull(30, "switch_bounce");
    applyStimulus(1, "switch_bounce_up");
    checkLedFull(30, "switch_bounce_up");
    bus.i_enable = 1'b0;
    mActive = 1'b0;
    @(posedge refclk); @(posedge refclk); @(negedge refclk);
    checkOutput("disable_led", {27'd0, bus.o_led}, 32'd0);
    checkOutput("disable_pos", 32'(bus.o_pos), 32'd0);
    applyStimulus(1, "step_disabled");
    checkLedFull(30, "step_disabled");
    bus.i_enable = 1'b1;

    // Blink at quarter duty; wait past a PWM wrap so the new duty is loaded.
    bus.i_duty = 8'd64;
    repeat (300) @(negedge refclk);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(2, $sformatf("blink%0d", i));
      checkLedDuty(64, $sformatf("blink%0d", i));
    end

    // Asynchronous reset between edges while chasing at pos 2.
    bus.i_duty = 8'd255;
    repeat (300) @(negedge refclk);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(0, $sformatf("pre_reset%0d", i));
      checkLedFull(30, $sformatf("pre_reset%0d", i));
    end
    #2 reset = 1'b1;
    #1 checkOutput("async_reset", {24'd0, bus.o_led, bus.o_step, bus.o_pos}, 32'd0);
    mActive = 1'b0;
    bus.i_flash = 1'b0;
    repeat (3) @(negedge refclk);
    reset = 1'b0;
    repeat (5) @(negedge refclk);
    applyStimulus(0, "post_reset");
    checkLedFull(30, "post_reset");

    // Randomized modes (including off) and step spacing.
    for (int i = 0; i < 40; i++) begin
      mode = int'($urandom_range(0, 3));
      applyStimulus(mode, $sformatf("rand%0d", i));
      checkLedFull(int'($urandom_range(16, 56)), $sformatf("rand%0d", i));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/led_pattern_sequencer.md
# led_pattern_sequencer

Downstream consumer of the flasher's toggling `o_led` output. Every flash-bit transition is one pattern step. Each step advances a multi-LED pattern (chase, bounce or blink) across the iCEBreaker LED bank, and lit LEDs are dimmed by a free-running PWM. The block sits between the flasher and the board LED pins and gives a visible check of clock rate, pattern logic and PWM.

## Interface
- `NUM_LEDS`, 5, number of LED outputs; must be at least 2 (elaboration error otherwise).
- `PWM_BITS`, 8, width of the PWM counter and of the duty input.
- `refclk` input 1: system clock.
- `reset` input 1: asynchronous, active-high reset.
- `i_flash` input 1: toggling flash bit from the flasher; treated as asynchronous.
- `i_enable` input 1: pattern enable; low forces all LEDs off.
- `i_mode` input 2: 0 = chase, 1 = bounce, 2 = blink, 3 = off.
- `i_duty` input PWM_BITS: brightness; 0 = dark.
- `o_led` output NUM_LEDS: registered LED drive, active-high.
- `o_step` output 1: one-cycle pulse on each pattern step.
- `o_pos` output clog2(NUM_LEDS): current pattern position.

## Operation
**Flash-edge detection**
- `i_flash` passes through a 2-flop synchronizer (reset 0), then a previous-value register.
- A step is detected when the synchronized value differs from the previous value. Both rising and falling transitions count as steps.

**State machine states:** IDLE, CHASE, BOUNCE_UP, BOUNCE_DN, BLINK.
- `i_enable`=0 or `i_mode`=3: the next clock edge goes to IDLE, regardless of step. In IDLE, pos=0 and the pattern is all zeros.
- Step in IDLE with enable=1 and mode≠3: enter the mode's state (mode 1 enters BOUNCE_UP) with pos=0. For BLINK, phase=1.
- Step in an active state whose mode no longer matches `i_mode`: re-enter the new mode's state with pos=0. This takes priority over advancing.
- CHASE: pos increments; after NUM_LEDS-1 it wraps to 0. Pattern is one-hot at pos.
- BOUNCE_UP: pos increments; the step that reaches NUM_LEDS-1 moves to BOUNCE_DN.
- BOUNCE_DN: pos decrements; the step that reaches 0 moves to BOUNCE_UP. With NUM_LEDS=5 the sequence is 0,1,2,3,4,3,2,1,0,1…
- BLINK: phase toggles on each step. Pattern is all ones when phase=1, all zeros otherwise. pos is held at 0.

**PWM**
- The PWM_BITS counter is free-running and wraps.
- Duty register loads `i_duty` only when the counter equals 0, so a duty change never produces a glitch.
- `o_led[i]` = pattern[i] AND (counter < duty_reg), registered.
- duty 0 means always off. Maximum duty means on for 2^PWM_BITS−1 of every 2^PWM_BITS cycles.

## Timing
- Reset values: `o_led`=0, `o_step`=0, `o_pos`=0, state IDLE, phase 0, synchronizer and edge registers 0, PWM counter 0, duty_reg 0.
- Asynchronous reset mid-pattern clears everything immediately. The first post-reset step is handled as coming from IDLE.
- Step latency: for an `i_flash` transition sampled at edge N, `o_step` is high for exactly the cycle after edge N+2. `o_pos` and the pattern update on that same edge N+2.
- `o_led` reflects the new pattern one edge later (N+3), gated by PWM.
- Transitions closer together than 3 clocks: behaviour is undefined. The flasher guarantees far wider spacing.
- A step and an `i_enable` fall on the same edge: IDLE wins and `o_step` still pulses.
- `i_mode` is sampled only on step edges, except mode 3, which acts at the next edge like enable=0.
- A duty change becomes visible at most 2^PWM_BITS cycles later, at the next counter wrap.

## Structure
- Shared package `led_seq_pkg` holds:
  - the state encoding (IDLE/CHASE/BOUNCE_UP/BOUNCE_DN/BLINK);
  - mode constants MODE_CHASE=0, MODE_BOUNCE=1, MODE_BLINK=2, MODE_OFF=3.
- One sub-module, `flash_edge_detect`: the 2-flop synchronizer, previous-value register, and registered one-cycle `step` output.
- The PWM counter, duty register and output gating stay inline.

## Test plan
- Reset held, then released with `i_flash` static → `o_led`=0, `o_pos`=0, `o_step`=0 for 1000 cycles.
- Chase, NUM_LEDS=5, duty=255, 12 `i_flash` toggles spaced 50 cycles → first `o_step` 3 edges after the first toggle. `o_pos` sequence 0,1,2,3,4,0,1,2,3,4,0,1. Exactly 12 `o_step` pulses, each 1 cycle wide.
- Bounce, 10 toggles → `o_pos` 0,1,2,3,4,3,2,1,0,1.
- Blink, duty=64, PWM_BITS=8 → on lit phases every LED is high for exactly 64 of 256 cycles. Dark phases are all zero.
- Mode changed chase→bounce at pos 3, then `i_enable` dropped mid-pattern → the next step gives pos=0 in BOUNCE_UP. After enable low, `o_led`=0 within 2 clocks with no further step needed.
- `reset` asserted asynchronously between clock edges during chase at pos 2 → all outputs 0 immediately. After release, the first step gives `o_pos`=0.
